pooling_max_unit: RTL

Streaming KERNEL_SIZE×KERNEL_SIZE max-pooling engine for IEEE-754 single-precision feature maps. It sits between the convolution layer output and the pooling output interface. It consumes conv pixels, interleaved by feature, in raster order. For each completed window it emits one pooled value tagged with feature index, input row and pooled column.

---
 rtl/pooling_max_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/pooling_max_unit.sv
// Streaming KxK max-pool over feature-interleaved IEEE-754 pixels; one registered result per closed window.
// Optional build macro POOL_RELU_EN clamps negative (and -0) results to +0.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pooling_max_lane #(
  parameter int DW  = 32,
  parameter int NPC = 3,
  parameter int PCW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           first_col,
  input  logic           last_col,
  input  logic           first_row,
  input  logic           last_row,
  input  logic [PCW-1:0] pcol,
  input  logic [DW-1:0]  pixel,
  output logic [DW-1:0]  v
);
  logic [DW-1:0]           hacc;
  logic [NPC-1:0][DW-1:0]  vbuf;
  logic [DW-1:0]           h;

  // Bitwise float max; ties keep the incumbent, NaN is just another bit pattern.
  function automatic logic [DW-1:0] fmax(input logic [DW-1:0] inc, input logic [DW-1:0] cand);
    logic take;
    if (inc[DW-1] != cand[DW-1]) take = ~cand[DW-1];
    else if (cand[DW-1])         take = cand[DW-2:0] < inc[DW-2:0];
    else                         take = cand[DW-2:0] > inc[DW-2:0];
    return take ? cand : inc;
  endfunction

  always_comb begin
    h = first_col ? pixel : fmax(hacc, pixel);
    v = first_row ? h : fmax(vbuf[pcol], h);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hacc <= '0;
      vbuf <= '0;
    end else if (en) begin
      if (!last_col)     hacc       <= h;
      else if (!last_row) vbuf[pcol] <= v;
    end
  end
endmodule

module pooling_max_unit #(
  parameter int INPUT_SIZE    = 6,
  parameter int KERNEL_SIZE   = 2,
  parameter int TOTAL_FEATURE = 4,
  localparam int DW  = `DATA_WIDTH,
  localparam int NPC = INPUT_SIZE / KERNEL_SIZE,
  localparam int FW  = (TOTAL_FEATURE > 1) ? $clog2(TOTAL_FEATURE) : 1,
  localparam int RW  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1,
  localparam int PCW = (NPC > 1) ? $clog2(NPC) : 1,
  localparam int KW  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           frame_start,
  input  logic [DW-1:0]  pixel_in,
  input  logic           pixel_valid,
  output logic [DW-1:0]  data_out,
  output logic           output_valid,
  output logic [FW-1:0]  feature_idx,
  output logic [RW-1:0]  feature_row,
  output logic [PCW-1:0] pool_col,
  output logic           busy,
  output logic           frame_done
);
  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [FW-1:0]  feat;
    logic [RW-1:0]  row;
    logic [RW-1:0]  col;
    logic [KW-1:0]  krow;
    logic [KW-1:0]  kcol;
    logic [PCW-1:0] pcol;
  } pos_t;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [FW-1:0]  feat;
    logic [RW-1:0]  row;
    logic [PCW-1:0] pcol;
  } pool_rsp_t;

  state_t    state, state_nxt;
  pos_t      pos, pos_e, pos_nxt;
  pool_rsp_t rsp;
  logic      beat, emit, frame_end;
  logic      last_feat, last_col, last_row, last_kcol, last_krow;
  logic [TOTAL_FEATURE-1:0]         lane_en;
  logic [TOTAL_FEATURE-1:0][DW-1:0] lane_v;
  logic [DW-1:0] win_max, win_out;

  // A beat that arrives with frame_start is beat 0 of the new frame.
  assign pos_e     = frame_start ? '0 : pos;
  assign beat      = pixel_valid & (frame_start | (state == RUN));
  assign last_feat = pos_e.feat == FW'(TOTAL_FEATURE - 1);
  assign last_col  = pos_e.col  == RW'(INPUT_SIZE - 1);
  assign last_row  = pos_e.row  == RW'(INPUT_SIZE - 1);
  assign last_kcol = pos_e.kcol == KW'(KERNEL_SIZE - 1);
  assign last_krow = pos_e.krow == KW'(KERNEL_SIZE - 1);
  assign emit      = beat & last_kcol & last_krow;
  assign frame_end = beat & last_feat & last_col & last_row;

  always_comb begin
    pos_nxt = pos_e;
    if (beat) begin
      if (!last_feat) begin
        pos_nxt.feat = pos_e.feat + FW'(1);
      end else begin
        pos_nxt.feat = '0;
        if (last_col) begin
          pos_nxt.col  = '0;
          pos_nxt.kcol = '0;
          pos_nxt.pcol = '0;
          pos_nxt.row  = last_row  ? '0 : pos_e.row + RW'(1);
          pos_nxt.krow = last_krow ? '0 : pos_e.krow + KW'(1);
        end else begin
          pos_nxt.col = pos_e.col + RW'(1);
          if (last_kcol) begin
            pos_nxt.kcol = '0;
            pos_nxt.pcol = pos_e.pcol + PCW'(1);
          end else begin
            pos_nxt.kcol = pos_e.kcol + KW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pos   <= '0;
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (frame_end)        state_nxt = IDLE;
    else if (frame_start) state_nxt = RUN;
  end

  always_comb begin
    busy = (state == RUN);
  end

  // One lane per feature; only the lane owning the current beat updates.
  for (genvar f = 0; f < TOTAL_FEATURE; f++) begin : g_lane
    assign lane_en[f] = beat & (pos_e.feat == FW'(f));
    pooling_max_lane #(.DW(DW), .NPC(NPC), .PCW(PCW)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (lane_en[f]),
      .first_col (pos_e.kcol == '0),
      .last_col  (last_kcol),
      .first_row (pos_e.krow == '0),
      .last_row  (last_krow),
      .pcol      (pos_e.pcol),
      .pixel     (pixel_in),
      .v         (lane_v[f])
    );
  end

  assign win_max = lane_v[pos_e.feat];
`ifdef POOL_RELU_EN
  assign win_out = win_max[DW-1] ? '0 : win_max;
`else
  assign win_out = win_max;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp          <= '0;
      output_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      output_valid <= emit;
      frame_done   <= frame_end;
      if (emit) rsp <= '{data: win_out, feat: pos_e.feat, row: pos_e.row, pcol: pos_e.pcol};
    end
  end

  assign data_out    = rsp.data;
  assign feature_idx = rsp.feat;
  assign feature_row = rsp.row;
  assign pool_col    = rsp.pcol;
endmodule
